// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter stage: sequencer states and the
// fetch increment.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC source select (jr > j > branch > sequential) with word-alignment check.
module pc_next_mux #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             jump_reg,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] sign_imm,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] next_pc,
  output logic             misaligned
);

  logic [WIDTH-1:0] branch_pc;

  // Branch offset is in words; the sum wraps at WIDTH bits.
  assign branch_pc = pc_plus4 + (sign_imm << 2);

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = rs_data;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_pc;
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, BOOT/RUN/HALT sequencing, sticky
// alignment error and retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] sign_imm,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             addr_err,
  output logic [CNT_W-1:0] retired
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             addr_err_q, addr_err_d;
  logic [WIDTH-1:0] next_pc;
  logic             misaligned;

  assign pc_plus4 = pc_q + WIDTH'(PC_INC);

  pc_next_mux #(
    .WIDTH(WIDTH)
  ) u_next_mux (
    .jump_reg    (jump_reg),
    .jump        (jump),
    .branch_taken(branch_taken),
    .pc_plus4    (pc_plus4),
    .sign_imm    (sign_imm),
    .jump_target (jump_target),
    .rs_data     (rs_data),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    addr_err_d  = addr_err_q;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        fetch_valid = 1'b1;
        if (halt_req) begin
          // The halting instruction itself still retires.
          state_d   = ST_HALT;
          retired_d = retired_q + CNT_W'(1);
        end else if (!stall) begin
          if (misaligned) begin
            addr_err_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + CNT_W'(1);
          end
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      retired_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc       = pc_q;
  assign addr_err = addr_err_q;
  assign retired  = retired_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle MIPS datapath.
- Holds the PC register and computes next-PC from four sources: sequential, branch, jump and jump-register.
- Consumes the 32-bit jump target produced by the upstream concat_2 instance ({pc_plus4[31:28], instr[25:0], 2'b00}).
- Adds stall, halt and misaligned-target detection, plus a retired-instruction counter.

Parameters:
- WIDTH, 32, PC/address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC; no retire this cycle.
- halt_req  input  1  syscall/break decoded; stop fetching.
- branch_taken  input  1  branch condition true (beq/bne resolved).
- jump  input  1  j/jal.
- jump_reg  input  1  jr/jalr.
- sign_imm  input  WIDTH  sign-extended branch immediate (word offset).
- jump_target  input  WIDTH  concatenated jump address from concat_2.
- rs_data  input  WIDTH  register operand for jr.
- pc  output  WIDTH  current fetch address.
- pc_plus4  output  WIDTH  pc + 4, combinational (feeds concat_2 and the link register).
- fetch_valid  output  1  pc is a valid fetch this cycle.
- halted  output  1  sequencer in HALT.
- addr_err  output  1  sticky: misaligned next-PC was selected.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VECTOR, state=BOOT, fetch_valid=0, halted=0, addr_err=0, retired=0. Reset mid-operation takes effect immediately, regardless of state.
- States:
  - BOOT: one cycle after reset release; pc holds RESET_VECTOR, fetch_valid=0; next state RUN unconditionally.
  - RUN: fetch_valid=1; pc updates each rising edge per the priority below.
  - HALT: fetch_valid=0, halted=1, pc frozen; exits only via reset.
- Next-PC priority in RUN, highest first:
  1. halt_req: go to HALT; pc holds; the halting instruction retires (retired+1).
  2. stall: pc holds; no retire; state stays RUN.
  3. jump_reg: next = rs_data.
  4. jump: next = jump_target.
  5. branch_taken: next = pc_plus4 + (sign_imm << 2), modulo 2^WIDTH.
  6. Otherwise: next = pc_plus4.
- Multiple control inputs asserted together resolve strictly by the priority above; no error is raised.
- Alignment check:
  - If the selected next value has bits[1:0] != 0, the PC is not updated.
  - addr_err sets, state goes to HALT, and the instruction does not retire.
  - addr_err stays set until reset.
- Arithmetic: pc_plus4 = pc + 4 wraps modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000). The branch sum wraps the same way.
- retired increments by 1 for each RUN cycle that is not stalled and has no alignment error. It wraps modulo 2^CNT_W with no saturation.
- Latency: a control input sampled at edge N is reflected in pc after edge N. pc_plus4 is combinational from pc.
- stall and halt_req are ignored in BOOT and HALT.

Decomposition:
- Shared include/package pc_defs: state encodings (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the PC_INC=4 constant.
- One combinational sub-module, pc_next_mux: priority select plus alignment check. Inputs: control bits, pc_plus4, sign_imm, jump_target, rs_data. Outputs: next_pc, misaligned.
- The state register, PC register and counter stay in pc_sequencer.

Test Plan:
- Reset/boot: rst_n low 3 cycles, then release, no controls -> pc=0, fetch_valid=0 for 1 cycle, then pc=4,8,12 on successive edges; retired=3 after 4 edges.
- Branch and jump:
  - At pc=0x10, branch_taken=1, sign_imm=0xFFFF_FFFE -> pc=0x0C.
  - At pc=0x0C, jump=1, jump_target=0x0040_0000 -> pc=0x0040_0000.
- Priority and stall:
  - jump_reg=1, rs_data=0x100, jump=1, branch_taken=1 together -> pc=0x100.
  - stall=1 for 2 cycles -> pc holds and retired holds.
- Misaligned jr: rs_data=0x102, jump_reg=1 -> addr_err=1, halted=1, pc unchanged, fetch_valid=0, retired unchanged.
- Halt: halt_req=1 at pc=0x20 -> halted=1, pc stays 0x20, retired+1; later stall/jump inputs have no effect.
- Wrap and async reset:
  - Force pc to 0xFFFF_FFFC via jr -> next pc=0x0.
  - Drop rst_n mid-cycle -> pc=RESET_VECTOR immediately, without waiting for a clock edge.
